// File: rtl/alu_logic_arbiter.sv
// alu_logic_arbiter
//
// Purpose:
//   Shares one W-bit bitwise logic unit (AND/OR/XOR/NOT) between two
//   requesters. A fair round-robin arbiter picks one request at a time through
//   a valid/ready handshake. The operation runs for one cycle. The result is
//   then held on a registered response port until the consumer takes it.
//
// Parameters:
//   W           operand/result width in bits (default 3)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   reqN_valid  requester N has an operation pending (N = 0, 1)
//   reqN_a      requester N operand A
//   reqN_b      requester N operand B
//   reqN_s      requester N op select:
//                 00 = A&B, 01 = A|B, 10 = A^B, 11 = ~A
//   reqN_ready  requester N is accepted this cycle (combinational)
//   res_valid   result available
//   res_data    result value
//   res_id      requester that owns res_data
//   res_ready   consumer accepts the result
//
// Optional build macro:
//   ALU_LOGIC_ARB_STATS_EN  adds cnt0/cnt1 (8 bits each). Each counter counts
//                           the handshakes granted to its requester and
//                           saturates at 255.

module alu_logic_arbiter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_s,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_s,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         res_id,
  input  logic         res_ready
`ifdef ALU_LOGIC_ARB_STATS_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         rr_ptr;
  logic         grant0;
  logic         grant1;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   op_s;
  logic         op_id;
  logic [W-1:0] logic_result;

  // Round-robin pick. A lone valid requester always wins. When both
  // requesters are valid, rr_ptr breaks the tie.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !rr_ptr);
    grant1 = req1_valid && (!req0_valid ||  rr_ptr);
  end

  // Next state and handshake outputs. The readies are only offered in IDLE
  // and are forced low while rst is high.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req0_ready = grant0;
          req1_ready = grant1;
          if (grant0 || grant1) begin
            state_next = EXEC;
          end
        end
      end
      EXEC: state_next = DONE;
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The logic unit works only on the latched operands. Operand changes after
  // the handshake therefore cannot affect the result.
  always_comb begin
    logic_result = '0;
    case (op_s)
      2'b00:   logic_result = op_a & op_b;
      2'b01:   logic_result = op_a | op_b;
      2'b10:   logic_result = op_a ^ op_b;
      default: logic_result = ~op_a;
    endcase
  end

  // Operand capture, round-robin update and the registered response.
  // After a grant, rr_ptr points at the loser so that the loser wins the
  // next tie. res_data keeps its value after the consumer takes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_s      <= 2'b00;
      op_id     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_a   <= req1_ready ? req1_a : req0_a;
            op_b   <= req1_ready ? req1_b : req0_b;
            op_s   <= req1_ready ? req1_s : req0_s;
            op_id  <= req1_ready;
            rr_ptr <= !req1_ready;
          end
        end
        EXEC: begin
          res_data  <= logic_result;
          res_id    <= op_id;
          res_valid <= 1'b1;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_LOGIC_ARB_STATS_EN
  // Per-requester grant counters. Each counter saturates at 255 and does not
  // wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (req0_ready && (cnt0 != 8'hFF)) begin
        cnt0 <= cnt0 + 8'd1;
      end
      if (req1_ready && (cnt1 != 8'hFF)) begin
        cnt1 <= cnt1 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// tb_alu_logic_arbiter
//
// Purpose:
//   Testbench for alu_logic_arbiter. It runs directed scenarios followed by a
//   randomized phase. A reference model tracks what the arbiter should do and
//   predicts the readies, the response registers and the counters every
//   cycle. The model pushes each expected result into a scoreboard queue when
//   it predicts a grant. A separate monitor pops the queue and compares
//   whenever the consumer takes a result.
//
// Optional build macro:
//   ALU_LOGIC_ARB_STATS_EN  also drives the saturating-counter scenario and
//                           checks cnt0/cnt1.

module tb_alu_logic_arbiter;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [1:0]   req0_s = 2'b00;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic [1:0]   req1_s = 2'b00;
  logic         req1_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         res_ready = 1'b0;
`ifdef ALU_LOGIC_ARB_STATS_EN
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;
`endif

  alu_logic_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_s     (req0_s),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_s     (req1_s),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready)
`ifdef ALU_LOGIC_ARB_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state. "free" means the unit can accept a request.
  // "computing" means the one-cycle operation is in flight. "presenting"
  // means a result waits for the consumer. The model values describe the
  // design after the most recent clock edge.
  bit           mdl_known      = 1'b0;
  bit           mdl_free       = 1'b0;
  bit           mdl_computing  = 1'b0;
  bit           mdl_presenting = 1'b0;
  bit           mdl_pref       = 1'b0;
  logic [W-1:0] mdl_data       = '0;
  logic         mdl_id         = 1'b0;
  logic [W-1:0] mdl_next_data  = '0;
  logic         mdl_next_id    = 1'b0;
  int           mdl_cnt0       = 0;
  int           mdl_cnt1       = 0;

  // Bitwise logic operation, computed one bit at a time.
  function automatic logic [W-1:0] expected_op(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (s)
        2'b00:   r[i] = a[i] & b[i];
        2'b01:   r[i] = a[i] | b[i];
        2'b10:   r[i] = a[i] ^ b[i];
        default: r[i] = !a[i];
      endcase
    end
    return r;
  endfunction

  // Records one comparison. On a mismatch, prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Drives every request-side input and res_ready, then holds them for the
  // given number of rising edges. Inputs change 1 unit after an edge.
  task automatic applyStimulus(input bit v0, input logic [W-1:0] a0,
                               input logic [W-1:0] b0, input logic [1:0] s0,
                               input bit v1, input logic [W-1:0] a1,
                               input logic [W-1:0] b1, input logic [1:0] s1,
                               input bit rr, input int cycles);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req0_s     = s0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    req1_s     = s1;
    res_ready  = rr;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model. On each falling edge it checks the visible outputs
  // against its prediction. It then advances its own view of the unit to
  // what the coming rising edge should produce.
  always @(negedge clk) begin
    bit win0;
    bit win1;
    exp_t e;
    if (mdl_known) begin
      checkOutput("res_valid", res_valid, mdl_presenting);
      checkOutput("res_data", res_data, mdl_data);
      checkOutput("res_id", res_id, mdl_id);
`ifdef ALU_LOGIC_ARB_STATS_EN
      checkOutput("cnt0", cnt0, mdl_cnt0);
      checkOutput("cnt1", cnt1, mdl_cnt1);
`endif
    end
    win0 = mdl_free && !rst && req0_valid && (!req1_valid || !mdl_pref);
    win1 = mdl_free && !rst && req1_valid && (!req0_valid ||  mdl_pref);
    checkOutput("req0_ready", req0_ready, win0);
    checkOutput("req1_ready", req1_ready, win1);
    if (rst) begin
      mdl_known      = 1'b1;
      mdl_free       = 1'b1;
      mdl_computing  = 1'b0;
      mdl_presenting = 1'b0;
      mdl_pref       = 1'b0;
      mdl_data       = '0;
      mdl_id         = 1'b0;
      mdl_cnt0       = 0;
      mdl_cnt1       = 0;
      exp_q.delete();
    end else if (mdl_free) begin
      if (win0 || win1) begin
        e.data = win1 ? expected_op(req1_a, req1_b, req1_s)
                      : expected_op(req0_a, req0_b, req0_s);
        e.id   = win1;
        exp_q.push_back(e);
        mdl_next_data = e.data;
        mdl_next_id   = e.id;
        mdl_pref      = win0;
        if (win0 && mdl_cnt0 < 255) mdl_cnt0++;
        if (win1 && mdl_cnt1 < 255) mdl_cnt1++;
        mdl_free      = 1'b0;
        mdl_computing = 1'b1;
      end
    end else if (mdl_computing) begin
      mdl_computing  = 1'b0;
      mdl_presenting = 1'b1;
      mdl_data       = mdl_next_data;
      mdl_id         = mdl_next_id;
    end else if (mdl_presenting && res_ready) begin
      mdl_presenting = 1'b0;
      mdl_free       = 1'b1;
    end
  end

  // Monitor. Whenever the consumer takes a result, pop the scoreboard and
  // compare.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && res_valid === 1'b1 && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL mon_unexpected: got result %0h id %0h, expected none at %0t",
                 res_data, res_id, $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("mon_data", res_data, e.data);
        checkOutput("mon_id", res_id, e.id);
      end
    end
  end

  // Watchdog. Ends the run if the main sequence overruns its budget.
  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bit           v0;
    bit           v1;
    bit           rr;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [1:0]   s0;
    logic [1:0]   s1;

    $display("[TB] reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] lone req0, AND");
    applyStimulus(1, 3'b101, 3'b011, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 1);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 4);

    $display("[TB] both valid, alternating grants");
    applyStimulus(1, 3'b100, 3'b001, 2'b01, 1, 3'b110, 3'b011, 2'b10, 1, 18);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 4);

    $display("[TB] result held while consumer stalls");
    applyStimulus(1, 3'b010, 3'b000, 2'b11, 0, 3'b000, 3'b000, 2'b00, 0, 1);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 0, 6);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 1);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 0, 2);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 3);

    $display("[TB] reset during operation");
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 1, 3'b111, 3'b101, 2'b10, 1, 1);
    rst = 1'b1;
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 1);
    rst = 1'b0;
    applyStimulus(1, 3'b011, 3'b110, 2'b00, 1, 3'b001, 3'b100, 2'b01, 1, 1);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 3) != 0);
      a0 = W'($urandom);
      b0 = W'($urandom);
      a1 = W'($urandom);
      b1 = W'($urandom);
      s0 = 2'($urandom);
      s1 = 2'($urandom);
      applyStimulus(v0, a0, b0, s0, v1, a1, b1, s1, rr, 1);
    end
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 4);

`ifdef ALU_LOGIC_ARB_STATS_EN
    $display("[TB] grant counter saturation");
    rst = 1'b1;
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 1);
    rst = 1'b0;
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 1, 3'b110, 3'b101, 2'b10, 1, 905);
    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 4);
    checkOutput("cnt1_saturated", cnt1, 32'd255);
    checkOutput("cnt0_zero", cnt0, 32'd0);
`endif

    applyStimulus(0, 3'b000, 3'b000, 2'b00, 0, 3'b000, 3'b000, 2'b00, 1, 6);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
